// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle for stream_rr_arbiter: NUM_REQ packed input streams and one merged output.
// "master" is the arbiter's view, "slave" is the view of the surrounding sources and sink.
interface stream_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 32,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ*DWIDTH-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]        s_axis_tvalid;
    logic [NUM_REQ-1:0]        s_axis_tlast;
    logic [NUM_REQ-1:0]        s_axis_tready;
    logic [DWIDTH-1:0]         m_axis_tdata;
    logic                      m_axis_tlast;
    logic [IDW-1:0]            m_axis_tid;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin merge of NUM_REQ streams onto one registered output stream.
// Define ARB_MAX_PKT_EN to force-terminate packets longer than MAX_BEATS beats.
module stream_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DWIDTH    = 32,
    parameter int IDW       = $clog2(NUM_REQ),
    parameter int MAX_BEATS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_rr_arbiter_if.master  bus,
    input  logic                 pause,
    output logic                 busy,
    output logic                 err_trunc
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    localparam int         IW       = IDW + 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BEATS < 1) begin : g_bad_cfg
            $error("stream_rr_arbiter: NUM_REQ must be 2..16 and MAX_BEATS >= 1");
        end
    endgenerate

    logic [0:0]        state_q, state_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_grant_q, last_grant_d;
    logic [DWIDTH-1:0] m_tdata_q, m_tdata_d;
    logic              m_tlast_q, m_tlast_d;
    logic [IDW-1:0]    m_tid_q, m_tid_d;
    logic              m_tvalid_q, m_tvalid_d;

    logic [DWIDTH-1:0] src_data [NUM_REQ];
    logic              core_rdy;
    logic              gnt_valid;
    logic              gnt_last;
    logic              accept;
    logic              trunc;
    logic              arb_found;
    logic [IDW-1:0]    arb_sel;
    logic [IW-1:0]     arb_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
            assign src_data[gi] = bus.s_axis_tdata[gi*DWIDTH +: DWIDTH];
            assign bus.s_axis_tready[gi] = (state_q == ST_GRANT) &&
                                           (grant_q == IDW'(gi)) && core_rdy;
        end
    endgenerate

    assign core_rdy  = bus.m_axis_tready | ~m_tvalid_q;
    assign gnt_valid = bus.s_axis_tvalid[grant_q];
    assign gnt_last  = bus.s_axis_tlast[grant_q];
    assign accept    = (state_q == ST_GRANT) && gnt_valid && core_rdy;
    assign busy      = (state_q == ST_GRANT);

    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign bus.m_axis_tid    = m_tid_q;
    assign bus.m_axis_tvalid = m_tvalid_q;

    // Scan starts one past the previous winner, so the previous winner is checked last.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            arb_idx = {1'b0, last_grant_q} + IW'(k);
            if (arb_idx >= IW'(NUM_REQ)) begin
                arb_idx = arb_idx - IW'(NUM_REQ);
            end
            if (!arb_found && bus.s_axis_tvalid[arb_idx[IDW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx[IDW-1:0];
            end
        end
    end

`ifdef ARB_MAX_PKT_EN
    localparam int CW = $clog2(MAX_BEATS) + 1;

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_trunc_q, err_trunc_d;

    assign trunc     = accept && !gnt_last && (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign err_trunc = err_trunc_q;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        err_trunc_d = err_trunc_q | trunc;
        if (state_q == ST_IDLE) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            err_trunc_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            err_trunc_q <= err_trunc_d;
        end
    end
`else
    assign trunc     = 1'b0;
    assign err_trunc = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tid_d      = m_tid_q;
        m_tvalid_d   = m_tvalid_q;

        if (accept) begin
            m_tdata_d  = src_data[grant_q];
            m_tlast_d  = gnt_last | trunc;
            m_tid_d    = grant_q;
            m_tvalid_d = 1'b1;
        end else if (bus.m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!pause && arb_found) begin
                    grant_d = arb_sel;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // pause is deliberately ignored here; a started packet always completes.
                if (accept && (gnt_last || trunc)) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
            m_tvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tid_q      <= m_tid_d;
            m_tvalid_q   <= m_tvalid_d;
        end
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-source beat queues feed the inputs and
// the expected merged beat order is queued alongside, then checked as beats leave.
module tb_stream_rr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MB = 8;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause = 1'b0;
    logic busy;
    logic err_trunc;

    stream_rr_arbiter_if #(.NUM_REQ(NR), .DWIDTH(DW), .IDW(IW)) bus ();

    stream_rr_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .IDW(IW), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .pause     (pause),
        .busy      (busy),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    logic [DW:0]   src_q [NR][$];
    beat_t         exp_q [$];
    logic [NR-1:0] src_en = '1;
    logic [NR-1:0] hs = '0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic send_beat(input int src, input logic [DW-1:0] data,
                             input logic src_last, input logic exp_last);
        beat_t e;
        src_q[src].push_back({src_last, data});
        e.tid  = IW'(src);
        e.last = exp_last;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic send_pkt(input int src, input int len, input int tag);
        for (int b = 0; b < len; b++) begin
            send_beat(src, {8'(src), 8'(tag), 16'(b)}, b == len - 1, b == len - 1);
        end
    endtask

    // Source driver: retire beats handshaken at the last edge, then present queue heads.
    initial begin
        logic [DW:0] h;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] === 1'b1 && src_q[i].size() != 0) begin
                    void'(src_q[i].pop_front());
                end
            end
            for (int i = 0; i < NR; i++) begin
                bus.s_axis_tvalid[i] = src_en[i] && (src_q[i].size() != 0);
                if (src_q[i].size() != 0) begin
                    h = src_q[i][0];
                    bus.s_axis_tdata[i*DW +: DW] = h[DW-1:0];
                    bus.s_axis_tlast[i]          = h[DW];
                end
            end
        end
    end

    // Output monitor: every accepted output beat must match the head of the scoreboard.
    initial begin
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            hs = bus.s_axis_tvalid & bus.s_axis_tready;
            if (!rst && bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                got = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL out_beat unexpected: got tid=%0d last=%0b data=%h, required none",
                             got.tid, got.last, got.data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL out_beat: got tid=%0d last=%0b data=%h, required tid=%0d last=%0b data=%h",
                                 got.tid, got.last, got.data, e.tid, e.last, e.data);
                    end else begin
                        $display("beat tid=%0d last=%0b data=%h", got.tid, got.last, got.data);
                    end
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && busy === 1'b0 && bus.m_axis_tvalid === 1'b0) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s drain timeout: %0d beats still expected, busy=%0b", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b required 0", bus.m_axis_tvalid); end
        n_checks++; if (bus.m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b required 0", bus.m_axis_tlast); end
        n_checks++; if (bus.m_axis_tid !== '0) begin n_fail++; $display("FAIL rst_tid got %0d required 0", bus.m_axis_tid); end
        n_checks++; if (bus.m_axis_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata got %h required 0", bus.m_axis_tdata); end
        n_checks++; if (bus.s_axis_tready !== '0) begin n_fail++; $display("FAIL rst_s_tready got %b required 0000", bus.s_axis_tready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b required 0", busy); end
        n_checks++; if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_err_trunc got %b required 0", err_trunc); end
        @(posedge clk);
        #1 rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_all_sources();
        logic exp_v;
        @(posedge clk);
        #1;
        for (int s = 0; s < NR; s++) send_pkt(s, 3, 1);
        // At the negedge after edge n: output valid on edges 2..4, 6..8, 10..12, 14..16.
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            exp_v = (n >= 2) && (n <= 16) && (((n - 2) % 4) != 3);
            n_checks++;
            if (bus.m_axis_tvalid !== exp_v) begin
                n_fail++;
                $display("FAIL all_src_valid cycle %0d: got %b required %b", n, bus.m_axis_tvalid, exp_v);
            end
            if (n == 0) begin
                n_checks++;
                if (bus.s_axis_tready !== 4'b0000 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL all_src_idle: got tready=%b busy=%b required 0000/0", bus.s_axis_tready, busy);
                end
            end
            if (n == 1) begin
                n_checks++;
                if (bus.s_axis_tready !== 4'b0001 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL all_src_grant0: got tready=%b busy=%b required 0001/1", bus.s_axis_tready, busy);
                end
            end
        end
        wait_drain("all_sources");
    endtask

    task automatic test_rotation();
        int prev = -1;
        int cnt = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            send_pkt(1, 1, 10 + k);
            send_pkt(2, 1, 20 + k);
        end
        for (int c = 0; c < 60 && cnt < 8; c++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
                if (prev >= 0) begin
                    n_checks++;
                    if (int'(bus.m_axis_tid) == prev) begin
                        n_fail++;
                        $display("FAIL rotation_repeat: got tid=%0d twice, required alternation", prev);
                    end
                end
                prev = int'(bus.m_axis_tid);
                cnt++;
            end
        end
        n_checks++;
        if (cnt != 8) begin n_fail++; $display("FAIL rotation_count: got %0d beats required 8", cnt); end
        wait_drain("rotation");
    endtask

    task automatic test_pause();
        @(posedge clk);
        #1;
        pause = 1'b1;
        send_pkt(0, 2, 30);
        send_pkt(1, 2, 31);
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (bus.s_axis_tready !== 4'b0000 || bus.m_axis_tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold: got tready=%b tvalid=%b required 0000/0", bus.s_axis_tready, bus.m_axis_tvalid);
            end
        end
        @(posedge clk);
        #1 pause = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.s_axis_tready !== 4'b0001) begin
            n_fail++;
            $display("FAIL pause_release: got busy=%b tready=%b required 1/0001", busy, bus.s_axis_tready);
        end
        wait_drain("pause");
    endtask

    task automatic test_stall();
        logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [DW+IW:0] held = '0;
        bit            have_held = 0;
        bit            seen = 0;
        send_pkt(2, 6, 40);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stall_start: got no output beat required one"); end
        @(posedge clk);
        #1 pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                @(posedge clk);
                #1;
            end
            bus.m_axis_tready = pat[k];
            @(negedge clk);
            if (bus.m_axis_tready === 1'b0 && bus.m_axis_tvalid === 1'b1) begin
                if (have_held) begin
                    n_checks++;
                    if ({bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata} !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h required %h",
                                 {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata}, held);
                    end
                end
                held = {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata};
                have_held = 1;
            end
        end
        n_checks++;
        if (!have_held) begin n_fail++; $display("FAIL stall_seen: got no stalled beat required one"); end
        @(posedge clk);
        #1 bus.m_axis_tready = 1'b1;
        wait_drain("stall");
        pause = 1'b0;
    endtask

    task automatic test_drop_valid();
        bit seen = 0;
        send_pkt(1, 4, 50);
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL drop_start: got no output beat required one"); end
        @(posedge clk);
        #1;
        src_en[1] = 1'b0;
        send_pkt(3, 2, 51);
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1 || bus.s_axis_tready[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_hold: got busy=%b tready3=%b required 1/0", busy, bus.s_axis_tready[3]);
            end
        end
        @(posedge clk);
        #1 src_en[1] = 1'b1;
        wait_drain("drop_valid");
    endtask

`ifdef ARB_MAX_PKT_EN
    task automatic test_trunc();
        n_checks++;
        if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_pre: got %b required 0", err_trunc); end
        @(posedge clk);
        #1;
        for (int b = 0; b < 10; b++) begin
            send_beat(0, {8'd0, 8'd60, 16'(b)}, b == 9, (b == MB - 1) || (b == 9));
        end
        wait_drain("trunc");
        n_checks++;
        if (err_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_flag: got %b required 1", err_trunc); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_clear: got %b required 0", err_trunc); end
    endtask
`else
    task automatic test_trunc();
        n_checks++;
        if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL trunc_off: got %b required 0", err_trunc); end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_sources();
        test_rotation();
        test_pause();
        test_stall();
        test_drop_valid();
        test_trunc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that merges NUM_REQ AXI-stream sources (typically easy_fifo outputs) onto one AXI-stream output.
- Holds a grant for a whole packet, ending on the tlast beat, then rotates priority.
- Honours a `pause` input, normally the downstream FIFO's `half_full`: no new packet starts while it is asserted.
- Output is a single registered stage, so every `m_axis_*` signal is driven from a flop.

Parameters:
- NUM_REQ, 4, number of input streams (2..16).
- DWIDTH, 32, data width per stream.
- IDW, $clog2(NUM_REQ), width of the source-ID field.
- MAX_BEATS, 256, packet beat limit; used only when ARB_MAX_PKT_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- s_axis_tdata  in  NUM_REQ*DWIDTH  per-source data; source i occupies bits [i*DWIDTH +: DWIDTH].
- s_axis_tvalid  in  NUM_REQ  per-source valid.
- s_axis_tlast  in  NUM_REQ  per-source end-of-packet.
- s_axis_tready  out  NUM_REQ  per-source ready.
- m_axis_tdata  out  DWIDTH  merged data.
- m_axis_tlast  out  1  merged end-of-packet.
- m_axis_tid  out  IDW  index of the source that owns the current beat.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- pause  in  1  when high, no new grant may be issued.
- busy  out  1  high while in GRANT state.
- err_trunc  out  1  sticky flag: a packet was force-terminated.

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-high.
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, m_axis_tdata=0.
  - s_axis_tready=0, busy=0, err_trunc=0.
  - state=IDLE, last_grant=NUM_REQ-1, so source 0 has first priority.
- Reset mid-packet: the packet is abandoned and the output register is emptied. No recovery of partial data.
- core_rdy = m_axis_tready | ~m_axis_tvalid.
- IDLE state:
  - s_axis_tready is all zero.
  - If pause=0 and any s_axis_tvalid is set, select the first valid source scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register the selection into `grant` and go to GRANT on the next clock.
  - If pause=1, stay in IDLE regardless of requests.
- GRANT state:
  - busy=1.
  - s_axis_tready[grant]=core_rdy; all other ready bits are 0.
- Beat acceptance (valid and ready on the granted source):
  - m_axis_tdata, m_axis_tlast and m_axis_tid load from that source; m_axis_tvalid<=1.
  - Otherwise, when m_axis_tready=1, m_axis_tvalid<=0.
- Packet end: when the accepted beat has tlast=1, set last_grant<=grant and return to IDLE.
- Pause during GRANT: ignored. The current packet always completes.
- Granted source drops tvalid mid-packet: the grant is held indefinitely; no other source is served.
- Latency:
  - First beat appears on m_axis 2 cycles after tvalid rises in IDLE: one arbitration cycle plus one register cycle.
  - Each packet costs exactly one IDLE cycle of input bubble.
  - Full throughput within a packet, one beat per cycle, while m_axis_tready=1.
- Output stability: m_axis_tdata, m_axis_tlast and m_axis_tid are stable while m_axis_tvalid=1 and m_axis_tready=0.
- Rotation: the same source cannot win twice in a row while another source is valid at arbitration time.
- Single requester: it wins every arbitration, giving back-to-back packets with a one-cycle gap.

Optional Feature:
- Macro: ARB_MAX_PKT_EN.
- When defined:
  - A beat counter of $clog2(MAX_BEATS)+1 bits counts accepted beats in the current grant.
  - On the MAX_BEATS-th beat without source tlast, that beat is output with m_axis_tlast forced to 1, err_trunc<=1 (sticky until rst), last_grant<=grant, and the state goes to IDLE.
  - The remaining beats of that source form subsequent "packets" under normal arbitration.
- When not defined: there is no counter, err_trunc is tied to 0, and grants last until source tlast.

Test Plan:
- Reset, then sources 0-3 each present a 3-beat packet in the same cycle, m_axis_tready=1 -> output order tid 0,0,0,1,1,1,2,2,2,3,3,3; tlast on every 3rd beat; first beat 2 cycles after tvalid; one bubble between packets.
- Source 2 sends 4 single-beat packets back-to-back while source 1 is also continuously valid -> tid sequence 1,2,1,2,... with no source winning twice consecutively.
- pause=1 while sources 0 and 1 are valid in IDLE -> s_axis_tready stays 0 and m_axis_tvalid stays 0. Deassert pause -> source 0 is granted the next cycle.
- Mid-packet, pause=1 and m_axis_tready toggles 1,0,0,1 -> packet completes; tdata, tlast and tid are held during the stall; no beat lost or duplicated; IDLE after tlast.
- Granted source drops tvalid for 5 cycles mid-packet while source 3 is valid -> busy stays 1, source 3 is not served, and the packet resumes intact.
- With ARB_MAX_PKT_EN and MAX_BEATS=8, a 10-beat packet on source 0 -> beat 8 carries m_axis_tlast=1 and err_trunc rises. The remaining 2 beats follow as a separate grant with tlast on beat 10. rst clears err_trunc.
